pulse_train_gen: RTL and testbench

- Transmit-side counterpart to the link receiver's edge detection: turns one-cycle command strobes into a clean level waveform with exactly timed rising and falling edges.
- Drives link control/strobe lines: programmable start delay, high width, low gap and pulse count.
- Sits between the control register bank (configuration, start/abort) and the output line.
- A downstream receiver-side edge detector sees exactly N rising and N falling edges per command.

---
 rtl/pulse_train_gen.sv | 126 ++++++++++++
 tb/tb_pulse_train_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: command-strobed pulse train generator.
// Start delay, high width, low gap and pulse count are latched at start.
module pulse_train_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay_cycles,
  input  logic [CNT_W-1:0] width_cycles,
  input  logic [CNT_W-1:0] gap_cycles,
  input  logic [NUM_W-1:0] pulse_count,
  output logic             signal_out,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulses_left
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    HIGH,
    LOW
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wid_m1;
  logic [CNT_W-1:0] gap_m1;

  logic [CNT_W-1:0] wid_in_m1;
  logic [CNT_W-1:0] gap_in_m1;
  logic [NUM_W-1:0] num_in;
  logic             cnt_zero;
  logic             last_pulse;

  // Zero width/gap/count act as one; keep width and gap as (value-1)
  // so the maximum input still fits and the counters never wrap.
  always_comb begin
    wid_in_m1  = '0;
    gap_in_m1  = '0;
    num_in     = pulse_count;
    cnt_zero   = (cnt == '0);
    last_pulse = (pulses_left == NUM_W'(1));
    if (width_cycles != '0) wid_in_m1 = width_cycles - 1'b1;
    if (gap_cycles != '0) gap_in_m1 = gap_cycles - 1'b1;
    if (pulse_count == '0) num_in = NUM_W'(1);
  end

  // Train sequencer: delay, then alternate high/low phases per pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wid_m1      <= '0;
      gap_m1      <= '0;
      signal_out  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_left <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state       <= IDLE;
        cnt         <= '0;
        signal_out  <= 1'b0;
        busy        <= 1'b0;
        pulses_left <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              state       <= DELAY;
              cnt         <= delay_cycles;
              wid_m1      <= wid_in_m1;
              gap_m1      <= gap_in_m1;
              pulses_left <= num_in;
              busy        <= 1'b1;
            end
          end
          DELAY: begin
            if (cnt_zero) begin
              state      <= HIGH;
              signal_out <= 1'b1;
              cnt        <= wid_m1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          HIGH: begin
            if (cnt_zero) begin
              signal_out  <= 1'b0;
              pulses_left <= pulses_left - 1'b1;
              if (last_pulse) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
                cnt   <= '0;
              end else begin
                state <= LOW;
                cnt   <= gap_m1;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          LOW: begin
            if (cnt_zero) begin
              state      <= HIGH;
              signal_out <= 1'b1;
              cnt        <= wid_m1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: randomized and directed checks of pulse_train_gen
// against a closed-form timing model of the waveform.
module tb_pulse_train_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [15:0] delay_cycles, width_cycles, gap_cycles;
  logic [7:0]  pulse_count;
  logic        signal_out, busy, done;
  logic [7:0]  pulses_left;

  logic        s_start, s_abort;
  logic [3:0]  s_d, s_w, s_g;
  logic [2:0]  s_n;
  logic        s_sig, s_busy, s_done;
  logic [2:0]  s_pl;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pulse_train_gen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .delay_cycles(delay_cycles), .width_cycles(width_cycles),
    .gap_cycles(gap_cycles), .pulse_count(pulse_count),
    .signal_out(signal_out), .busy(busy), .done(done),
    .pulses_left(pulses_left)
  );

  pulse_train_gen #(.CNT_W(4), .NUM_W(3)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
    .delay_cycles(s_d), .width_cycles(s_w),
    .gap_cycles(s_g), .pulse_count(s_n),
    .signal_out(s_sig), .busy(s_busy), .done(s_done),
    .pulses_left(s_pl)
  );

  function automatic int one_if_zero(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic int last_fall(input int d, w, g, n);
    return d + 1 + (one_if_zero(n) - 1) * (one_if_zero(w) + one_if_zero(g))
           + one_if_zero(w);
  endfunction

  // Expected {signal, busy, done, pulses_left} after edge T0+t.
  function automatic logic [10:0] model(input int d, w0, g0, n0, t);
    int w, g, n, p, r0, last, falls;
    logic s;
    w = one_if_zero(w0);
    g = one_if_zero(g0);
    n = one_if_zero(n0);
    p = w + g;
    r0 = d + 1;
    last = r0 + (n - 1) * p + w;
    s = (t >= r0) && (t < last) && (((t - r0) % p) < w);
    if (t < r0 + w) falls = 0;
    else begin
      falls = (t - r0 - w) / p + 1;
      if (falls > n) falls = n;
    end
    return {s, t < last, t == last, 8'(n - falls)};
  endfunction

  task automatic launch(input int d, w, g, n);
    @(negedge clk);
    start = 1'b1;
    delay_cycles = 16'(d);
    width_cycles = 16'(w);
    gap_cycles = 16'(g);
    pulse_count = 8'(n);
    @(posedge clk);
  endtask

  task automatic scramble();
    delay_cycles = 16'($urandom);
    width_cycles = 16'($urandom);
    gap_cycles = 16'($urandom);
    pulse_count = 8'($urandom);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({signal_out, busy, done, pulses_left} !== 11'd0)
      $display("FAIL reset_async got=%b exp=0",
               {signal_out, busy, done, pulses_left});
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({signal_out, busy, done, pulses_left, s_sig, s_busy, s_done, s_pl}
        !== 17'd0)
      $display("FAIL reset_idle got=%b exp=0",
               {signal_out, busy, done, pulses_left});
    else passed++;
  endtask

  task automatic test_single(input string nm, input int d, w, g, n);
    logic [10:0] e;
    int last;
    last = last_fall(d, w, g, n);
    launch(d, w, g, n);
    for (int t = 0; t <= last + 2; t++) begin
      @(negedge clk);
      if (t == 0) begin start = 1'b0; scramble(); end
      e = model(d, w, g, n, t);
      checks++;
      if ({signal_out, busy, done, pulses_left} !== e)
        $display("FAIL %s t=%0d got=%b exp=%b", nm, t,
                 {signal_out, busy, done, pulses_left}, e);
      else passed++;
    end
  endtask

  task automatic test_random();
    int d, w, g, n;
    for (int i = 0; i < 10; i++) begin
      d = $urandom_range(0, 6);
      w = $urandom_range(0, 4);
      g = $urandom_range(0, 4);
      n = $urandom_range(0, 5);
      test_single("random", d, w, g, n);
    end
  endtask

  task automatic test_start_ignored();
    logic [10:0] e;
    launch(0, 2, 1, 3);
    for (int t = 0; t <= 11; t++) begin
      @(negedge clk);
      if (t == 0) begin start = 1'b0; scramble(); end
      e = model(0, 2, 1, 3, t);
      checks++;
      if ({signal_out, busy, done, pulses_left} !== e)
        $display("FAIL start_busy t=%0d got=%b exp=%b", t,
                 {signal_out, busy, done, pulses_left}, e);
      else passed++;
      start = (t == 1);
    end
  endtask

  task automatic test_abort();
    logic [10:0] e;
    launch(0, 2, 1, 3);
    for (int t = 0; t <= 12; t++) begin
      @(negedge clk);
      if (t == 0) begin start = 1'b0; scramble(); end
      e = (t < 5) ? model(0, 2, 1, 3, t) : 11'd0;
      checks++;
      if ({signal_out, busy, done, pulses_left} !== e)
        $display("FAIL abort t=%0d got=%b exp=%b", t,
                 {signal_out, busy, done, pulses_left}, e);
      else passed++;
      abort = (t == 4);
    end
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    pulse_count = 8'd2;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int t = 0; t < 3; t++) begin
      checks++;
      if ({signal_out, busy, done, pulses_left} !== 11'd0)
        $display("FAIL abort_idle t=%0d got=%b exp=0", t,
                 {signal_out, busy, done, pulses_left});
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    int l1, l2;
    l1 = last_fall(1, 2, 2, 2);
    l2 = last_fall(0, 1, 3, 2);
    launch(1, 2, 2, 2);
    for (int t = 0; t <= l1; t++) begin
      @(negedge clk);
      if (t == 0) begin
        delay_cycles = 16'd0;
        width_cycles = 16'd1;
        gap_cycles = 16'd3;
        pulse_count = 8'd2;
      end
      e = model(1, 2, 2, 2, t);
      checks++;
      if ({signal_out, busy, done, pulses_left} !== e)
        $display("FAIL b2b_first t=%0d got=%b exp=%b", t,
                 {signal_out, busy, done, pulses_left}, e);
      else passed++;
    end
    @(posedge clk);
    for (int t = 0; t <= l2 + 1; t++) begin
      @(negedge clk);
      if (t == 0) begin start = 1'b0; scramble(); end
      e = model(0, 1, 3, 2, t);
      checks++;
      if ({signal_out, busy, done, pulses_left} !== e)
        $display("FAIL b2b_second t=%0d got=%b exp=%b", t,
                 {signal_out, busy, done, pulses_left}, e);
      else passed++;
    end
  endtask

  task automatic test_async_rst();
    logic [10:0] e;
    launch(0, 5, 1, 2);
    for (int t = 0; t <= 2; t++) begin
      @(negedge clk);
      if (t == 0) start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({signal_out, busy, done, pulses_left} !== 11'd0)
      $display("FAIL async_rst got=%b exp=0",
               {signal_out, busy, done, pulses_left});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    test_single("after_rst", 1, 1, 0, 1);
  endtask

  task automatic test_max();
    int d[2] = '{15, 15};
    int w[2] = '{15, 15};
    int g[2] = '{0, 15};
    int n[2] = '{1, 7};
    logic [10:0] e;
    int last;
    for (int i = 0; i < 2; i++) begin
      last = last_fall(d[i], w[i], g[i], n[i]);
      @(negedge clk);
      s_start = 1'b1;
      s_d = 4'(d[i]);
      s_w = 4'(w[i]);
      s_g = 4'(g[i]);
      s_n = 3'(n[i]);
      @(posedge clk);
      for (int t = 0; t <= last + 2; t++) begin
        @(negedge clk);
        if (t == 0) begin
          s_start = 1'b0;
          s_d = 4'($urandom);
          s_w = 4'($urandom);
        end
        e = model(d[i], w[i], g[i], n[i], t);
        checks++;
        if ({s_sig, s_busy, s_done, s_pl} !== {e[10:8], e[2:0]})
          $display("FAIL max%0d t=%0d got=%b exp=%b", i, t,
                   {s_sig, s_busy, s_done, s_pl}, {e[10:8], e[2:0]});
        else passed++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    delay_cycles = '0;
    width_cycles = '0;
    gap_cycles = '0;
    pulse_count = '0;
    s_start = 1'b0;
    s_abort = 1'b0;
    s_d = '0;
    s_w = '0;
    s_g = '0;
    s_n = '0;
    test_reset();
    test_single("d3w2n1", 3, 2, 0, 1);
    test_single("zeros", 0, 0, 0, 0);
    test_single("d0w2g1n3", 0, 2, 1, 3);
    test_random();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_async_rst();
    test_max();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
